// File: rtl/id_ex_skid.sv
// id_ex_skid: ID->EX pipeline register with a 2-entry skid buffer and flush.
// id_ready comes straight from the state register, so it has no
// combinational path from ex_ready. Entries leave in FIFO order: main, then skid.
// Optional build macro ID_EX_STALL_CNT_EN adds the 32-bit stall_cnt output.
module id_ex_skid #(
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter logic [ALUOP_W-1:0]  NOP_ALUOP  = '0,
    parameter logic [ALUSEL_W-1:0] NOP_ALUSEL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_reg1,
    input  logic [DATA_W-1:0]   id_reg2,
    input  logic [RADDR_W-1:0]  id_wd,
    input  logic                id_wreg,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_reg1,
    output logic [DATA_W-1:0]   ex_reg2,
    output logic [RADDR_W-1:0]  ex_wd,
    output logic                ex_wreg
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    typedef struct packed {
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
        logic [DATA_W-1:0]   reg1;
        logic [DATA_W-1:0]   reg2;
        logic [RADDR_W-1:0]  wd;
        logic                wreg;
    } beat_t;

    localparam beat_t BUBBLE = '{aluop: NOP_ALUOP, alusel: NOP_ALUSEL,
                                 reg1: '0, reg2: '0, wd: '0, wreg: 1'b0};

    // Encoding is {skid_full, main_full}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } state_t;

    state_t state, state_d;
    beat_t  main_q, skid_q, main_d, id_beat;
    logic   main_ld, main_clr, main_from_skid, skid_ld;

    assign id_beat = '{aluop: id_aluop, alusel: id_alusel, reg1: id_reg1,
                       reg2: id_reg2, wd: id_wd, wreg: id_wreg};

    // State register; reset drops both entries at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_d;
    end

    // Next state and load controls; flush overrides every handshake.
    always_comb begin
        state_d        = state;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
        end else begin
            case (state)
                EMPTY: if (id_valid) begin
                    state_d = FULL;
                    main_ld = 1'b1;
                end
                FULL: begin
                    if (ex_ready && id_valid) begin
                        main_ld = 1'b1;
                    end else if (ex_ready) begin
                        state_d  = EMPTY;
                        main_clr = 1'b1;
                    end else if (id_valid) begin
                        state_d = SKID;
                        skid_ld = 1'b1;
                    end
                end
                SKID: if (ex_ready) begin
                    state_d        = FULL;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                end
            endcase
        end
    end

    // Any entry into EMPTY reloads the bubble so ex_wreg can never leak.
    always_comb begin
        main_d = id_beat;
        if (main_clr)            main_d = BUBBLE;
        else if (main_from_skid) main_d = skid_q;
    end

    // Main register drives EX directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   main_q <= BUBBLE;
        else if (main_ld || main_clr) main_q <= main_d;
    end

    // Skid register only captures the beat that arrives while EX stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         skid_q <= BUBBLE;
        else if (skid_ld) skid_q <= id_beat;
    end

    assign ex_valid  = state[0];
    assign id_ready  = ~state[1];
    assign ex_aluop  = main_q.aluop;
    assign ex_alusel = main_q.alusel;
    assign ex_reg1   = main_q.reg1;
    assign ex_reg2   = main_q.reg2;
    assign ex_wd     = main_q.wd;
    assign ex_wreg   = main_q.wreg;

`ifdef ID_EX_STALL_CNT_EN
    // Counts cycles EX holds off a valid beat; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     stall_cnt <= '0;
        else if (ex_valid && !ex_ready) stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/id_ex_skid.md
Name: id_ex_skid

Overview:
- Parametrised ID->EX pipeline stage register with a valid/ready handshake on both sides.
- Includes a 2-entry skid buffer, so id_ready is driven from a register and does not depend combinationally on ex_ready.
- Adds synchronous flush for branch/exception squash.
- Sits between the decoder and the ALU. Carries aluop, alusel, both operands, destination address and write enable.

Parameters:
- ALUOP_W, 8, width of aluop field
- ALUSEL_W, 3, width of alusel field
- DATA_W, 32, operand width
- RADDR_W, 5, register-address width
- NOP_ALUOP, 0, aluop value of a bubble
- NOP_ALUSEL, 0, alusel value of a bubble

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- flush  in  1  synchronous squash of all held entries
- id_valid  in  1  upstream beat present
- id_ready  out  1  stage can accept a beat (registered)
- id_aluop  in  ALUOP_W  decoded op
- id_alusel  in  ALUSEL_W  result-select class
- id_reg1  in  DATA_W  operand 1
- id_reg2  in  DATA_W  operand 2
- id_wd  in  RADDR_W  destination register
- id_wreg  in  1  destination write enable
- ex_valid  out  1  beat present to EX
- ex_ready  in  1  EX consumes the beat
- ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg  out  widths as the id_ fields  registered payload to EX
- stall_cnt  out  32  only present with STALL_CNT_EN

Behaviour:
- Handshake:
  - Accept when id_valid & id_ready.
  - Pop when ex_valid & ex_ready.
  - A beat is never dropped or duplicated except by flush.
- Storage:
  - Main register drives the ex_* outputs.
  - Skid register holds at most one extra beat.
  - id_ready = !skid_full, registered, no combinational path from ex_ready.
- States (encoded by main_full, skid_full):
  - EMPTY:
    - id_valid -> load main, go FULL.
  - FULL:
    - ex_ready & id_valid -> reload main, stay FULL.
    - ex_ready & !id_valid -> go EMPTY.
    - !ex_ready & id_valid -> load skid, go SKID.
    - otherwise hold.
  - SKID (id_ready=0):
    - ex_ready -> main<=skid, go FULL.
    - otherwise hold main and skid unchanged.
- Bubble rule:
  - Whenever main is empty, ex_aluop=NOP_ALUOP, ex_alusel=NOP_ALUSEL, ex_reg1=ex_reg2=0, ex_wd=0, ex_wreg=0.
  - The payload registers are loaded with these constants on any transition into EMPTY.
  - ex_wreg is therefore never 1 while ex_valid=0.
- Latency and throughput:
  - 1 cycle from accept into an EMPTY stage to ex_valid=1.
  - Sustained 1 beat/cycle while ex_ready=1.
- Flush:
  - Highest priority. At the next edge both entries are cleared, state goes EMPTY, and payload goes to the bubble values.
  - A beat accepted in the flush cycle is discarded.
  - ex_ready in the flush cycle is ignored.
  - id_ready returns to 1 in the cycle after flush.
- Reset (rst=0, asynchronous):
  - State EMPTY, ex_valid=0, id_ready=1.
  - All ex_* outputs at bubble values.
  - stall_cnt=0.
  - Release is synchronous to the first clk edge with rst=1; no handshake occurs in that edge's preceding cycle.
- Reset asserted mid-transfer: all beats in main and skid are lost, with no partial update.
- Skid fill ordering is FIFO: the skid beat always reaches EX after the main beat.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with ex_valid=1 & ex_ready=0.
  - Wraps at 2^32-1 -> 0.
  - Cleared by reset only; not cleared by flush.
- Not defined: stall_cnt port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then single beat: rst=0 for 3 cycles, release, drive id_valid=1, aluop=0x21, reg1=5, reg2=7, wd=3, wreg=1 with ex_ready=1 -> ex_valid=1 next cycle with those exact values; the following cycle ex_valid=0 and ex_wreg=0.
- Back-to-back stream: 8 beats with reg1=0..7 and ex_ready=1 throughout -> EX sees reg1=0..7 in order, one per cycle, id_ready stays 1.
- Skid fill: beats A (reg1=1) and B (reg1=2) on consecutive cycles with ex_ready=0 -> id_ready=0 after B is accepted; raise ex_ready -> EX sees A then B, id_ready=1 once B is in main.
- Flush in SKID: state holds A and B, assert flush with id_valid=1 carrying C -> next cycle ex_valid=0, ex_aluop=0, ex_wreg=0, id_ready=1; A, B and C never appear on the EX side.
- Async reset mid-stream: drop rst between clock edges while FULL -> ex_valid=0 and ex_wd=0 immediately, without waiting for a clk edge.
- ID_EX_STALL_CNT_EN defined: hold ex_ready=0 for 10 cycles with one beat in main -> stall_cnt=10; a flush leaves stall_cnt=10.
